cdc_conversion_sequencer: RTL and testbench

Synchronous controller that drives the asynchronous CDC edge generator through a full conversion: it releases generator reset, answers each Next_Edge/OE phase with Done_Rising/Done_Falling after a programmable settle time, and counts completed periods. It requests termination through active-low Finish, then waits for Conv_Finish. Result is the number of CLK cycles the requested periods took, so the block is the digital time-measurement end of the converter. It sits between the register/host interface and the generator.

---
 rtl/cdc_conversion_sequencer.sv | 170 +++++++++++++++++
 tb/tb_cdc_conversion_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_conversion_sequencer.sv
// rtl/cdc_conversion_sequencer.sv - sequences the CDC edge generator through one timed conversion
module cdc_conversion_sequencer #(
  parameter int CNT_W   = 8,
  parameter int SET_W   = 6,
  parameter int RES_W   = 20,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk_i,
  input  logic             resetb_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_cycles_i,
  input  logic [SET_W-1:0] settle_cycles_i,
  input  logic             oe_falling_i,
  input  logic             conv_finish_i,
  output logic             reset_o,
  output logic             finish_o,
  output logic             finish_delay_o,
  output logic             done_rising_o,
  output logic             done_falling_o,
  output logic             busy_o,
  output logic [RES_W-1:0] result_o,
  output logic             result_valid_o,
  output logic             error_o
);

  // One shared wait counter covers both the settle count and the response timeout.
  localparam int TW     = $clog2(TIMEOUT + 1);
  localparam int WAIT_W = (TW > SET_W) ? TW : SET_W;
  localparam logic [WAIT_W-1:0] TO_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [RES_W-1:0]  RES_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_SETTLE, S_DONE, S_FINISH, S_CLEAR
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        oe_sync_q, conv_sync_q;
  logic [CNT_W-1:0]  num_q, period_q;
  logic [SET_W-1:0]  settle_q;
  logic [WAIT_W-1:0] wait_q;
  logic [RES_W-1:0]  elapsed_q, result_q;
  logic              phase_f_q;   // 1: phase F (OE_Falling high), 0: phase R
  logic              fd_q, valid_q, error_q;

  logic              oe_s, conv_s;
  logic              toggle, last_period, timed_out, settle_done;
  logic [RES_W-1:0]  elapsed_inc;

  assign oe_s        = oe_sync_q[1];
  assign conv_s      = conv_sync_q[1];
  assign toggle      = (oe_s != phase_f_q);
  assign last_period = !phase_f_q && ((period_q + CNT_W'(1)) == num_q);
  assign timed_out   = (wait_q == TO_LAST);
  assign settle_done = (wait_q == WAIT_W'(settle_q));
  assign elapsed_inc = (elapsed_q == RES_MAX) ? RES_MAX : elapsed_q + RES_W'(1);

  // State register.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state decision: handshake progress first, timeout as the fallback.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start_i) state_d = S_ARM;
      S_ARM:    if (oe_s) state_d = S_SETTLE;
                else if (timed_out) state_d = S_CLEAR;
      S_SETTLE: if (settle_done) state_d = S_DONE;
      S_DONE:   if (toggle) state_d = last_period ? S_FINISH : S_SETTLE;
                else if (timed_out) state_d = S_CLEAR;
      S_FINISH: if (conv_s || timed_out) state_d = S_CLEAR;
      S_CLEAR:  if (!conv_s || timed_out) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Generator-facing controls decoded from state; async reset lands them on IDLE values at once.
  always_comb begin
    reset_o        = 1'b1;
    finish_o       = 1'b1;
    done_rising_o  = 1'b0;
    done_falling_o = 1'b0;
    unique case (state_q)
      S_ARM:    begin reset_o = 1'b0; done_falling_o = 1'b1; end
      S_SETTLE: reset_o = 1'b0;
      S_DONE:   begin
                  reset_o        = 1'b0;
                  done_rising_o  = phase_f_q;
                  done_falling_o = !phase_f_q;
                end
      S_FINISH: begin reset_o = 1'b0; finish_o = 1'b0; end
      default:  ;
    endcase
  end

  // Synchronizers, counters, phase tracking and the measurement result.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      oe_sync_q   <= '0;
      conv_sync_q <= '0;
      num_q       <= '0;
      period_q    <= '0;
      settle_q    <= '0;
      wait_q      <= '0;
      elapsed_q   <= '0;
      result_q    <= '0;
      phase_f_q   <= 1'b1;
      fd_q        <= 1'b0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      oe_sync_q   <= {oe_sync_q[0], oe_falling_i};
      conv_sync_q <= {conv_sync_q[0], conv_finish_i};
      wait_q      <= (state_q == S_IDLE || state_d != state_q) ? '0 : wait_q + WAIT_W'(1);
      unique case (state_q)
        S_IDLE: if (start_i) begin
          num_q     <= (num_cycles_i == '0) ? CNT_W'(1) : num_cycles_i;
          settle_q  <= settle_cycles_i;
          period_q  <= '0;
          elapsed_q <= '0;
          phase_f_q <= 1'b1;
          fd_q      <= 1'b0;
          valid_q   <= 1'b0;
          error_q   <= 1'b0;
        end
        S_ARM: if (oe_s) begin
          elapsed_q <= '0;
          phase_f_q <= 1'b1;
          fd_q      <= 1'b1;
        end else if (timed_out) begin
          error_q <= 1'b1;
        end
        S_SETTLE: elapsed_q <= elapsed_inc;
        S_DONE: begin
          elapsed_q <= elapsed_inc;
          if (toggle) begin
            if (!phase_f_q) period_q <= period_q + CNT_W'(1);
            // Finish_Delay only moves on the edge into SETTLE, never while a strobe is up.
            if (!last_period) begin
              phase_f_q <= !phase_f_q;
              fd_q      <= !phase_f_q;
            end
          end else if (timed_out) begin
            error_q <= 1'b1;
          end
        end
        S_FINISH: begin
          elapsed_q <= elapsed_inc;
          if (conv_s) begin
            result_q <= elapsed_inc;
            valid_q  <= 1'b1;
          end else if (timed_out) begin
            error_q <= 1'b1;
          end
        end
        S_CLEAR: if (conv_s && timed_out) error_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign finish_delay_o = fd_q;
  assign busy_o         = (state_q != S_IDLE);
  assign result_o       = result_q;
  assign result_valid_o = valid_q;
  assign error_o        = error_q;

endmodule

// File: tb/tb_cdc_conversion_sequencer.sv
// tb/tb_cdc_conversion_sequencer.sv - randomized self-checking bench with a behavioural generator model
`timescale 1ns/1ps
module tb_cdc_conversion_sequencer;

  localparam int RESP = 5;
  localparam int TO   = 1023;

  typedef struct packed {
    logic       oe;
    logic       conv;
    logic [3:0] oe_cnt;
    logic [3:0] conv_cnt;
    logic       frozen;
  } gen_t;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [7:0] num_a = '0, num_b = '0;
  logic [5:0] settle_a = '0, settle_b = '0;
  logic       freeze_a = 1'b0;
  logic       sel_b = 1'b0;
  gen_t       ga = '0;
  gen_t       gb = '0;

  logic        a_reset, a_finish, a_fd, a_dr, a_df, a_busy, a_valid, a_error;
  logic [19:0] a_result;
  logic        b_reset, b_finish, b_fd, b_dr, b_df, b_busy, b_valid, b_error;
  logic [3:0]  b_result;

  logic        o_reset, o_finish, o_fd, o_dr, o_df, o_busy, o_valid, o_error;
  logic [19:0] o_result;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cdc_conversion_sequencer u_dut (
    .clk_i(clk), .resetb_i(resetb), .start_i(start_a), .num_cycles_i(num_a),
    .settle_cycles_i(settle_a), .oe_falling_i(ga.oe), .conv_finish_i(ga.conv),
    .reset_o(a_reset), .finish_o(a_finish), .finish_delay_o(a_fd),
    .done_rising_o(a_dr), .done_falling_o(a_df), .busy_o(a_busy),
    .result_o(a_result), .result_valid_o(a_valid), .error_o(a_error)
  );

  cdc_conversion_sequencer #(.RES_W(4)) u_sat (
    .clk_i(clk), .resetb_i(resetb), .start_i(start_b), .num_cycles_i(num_b),
    .settle_cycles_i(settle_b), .oe_falling_i(gb.oe), .conv_finish_i(gb.conv),
    .reset_o(b_reset), .finish_o(b_finish), .finish_delay_o(b_fd),
    .done_rising_o(b_dr), .done_falling_o(b_df), .busy_o(b_busy),
    .result_o(b_result), .result_valid_o(b_valid), .error_o(b_error)
  );

  assign o_reset  = sel_b ? b_reset  : a_reset;
  assign o_finish = sel_b ? b_finish : a_finish;
  assign o_fd     = sel_b ? b_fd     : a_fd;
  assign o_dr     = sel_b ? b_dr     : a_dr;
  assign o_df     = sel_b ? b_df     : a_df;
  assign o_busy   = sel_b ? b_busy   : a_busy;
  assign o_valid  = sel_b ? b_valid  : a_valid;
  assign o_error  = sel_b ? b_error  : a_error;
  assign o_result = sel_b ? {16'd0, b_result} : a_result;

  // Generator: each output follows its requested value RESP clocks after the request appears.
  function automatic gen_t gen_step(gen_t g, logic rst, logic fin, logic dr, logic df, logic freeze);
    logic toe, tconv;
    toe   = g.oe;
    tconv = g.conv;
    if (rst) begin
      toe = 1'b0; tconv = 1'b0; g.frozen = 1'b0;
    end else begin
      if (!fin) tconv = 1'b1;
      if (dr) toe = 1'b0;
      else if (df) toe = 1'b1;
      if (dr && freeze) g.frozen = 1'b1;
    end
    if (g.frozen) toe = g.oe;
    if (toe != g.oe) begin
      if (g.oe_cnt == 4'(RESP - 1)) begin g.oe = toe; g.oe_cnt = '0; end
      else g.oe_cnt = g.oe_cnt + 4'd1;
    end else g.oe_cnt = '0;
    if (tconv != g.conv) begin
      if (g.conv_cnt == 4'(RESP - 1)) begin g.conv = tconv; g.conv_cnt = '0; end
      else g.conv_cnt = g.conv_cnt + 4'd1;
    end else g.conv_cnt = '0;
    return g;
  endfunction

  always @(negedge clk) begin
    ga = gen_step(ga, a_reset, a_finish, a_dr, a_df, freeze_a);
    gb = gen_step(gb, b_reset, b_finish, b_dr, b_df, 1'b0);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int   s_idx, v_idx, dr_first, err_idx, dr_high, fin_falls, viol;
  int   strobes[$];
  logic p_dr, p_df, p_fd, p_fin;
  logic end_valid, end_error;
  logic [19:0] end_result;

  // One full conversion: the expected behaviour comes from the period/phase rules and
  // from the measurement window, first Finish_Delay=1 cycle up to the Result_Valid cycle.
  task automatic run_conv(input logic sb, input int num, input int settle, input logic freeze, input bit probe);
    int n_eff, exp_res, res_max;
    n_eff   = (num == 0) ? 1 : num;
    res_max = sb ? 15 : (1 << 20) - 1;
    sel_b    = sb;
    freeze_a = freeze;
    if (sb) begin num_b = num[7:0]; settle_b = settle[5:0]; start_b = 1'b1; end
    else    begin num_a = num[7:0]; settle_a = settle[5:0]; start_a = 1'b1; end
    cyc();
    start_a = 1'b0;
    start_b = 1'b0;
    chk("busy_after_start", o_busy, 1);
    chk("reset_fall_1clk", o_reset, 0);
    s_idx = -1; v_idx = -1; dr_first = -1; err_idx = -1;
    dr_high = 0; fin_falls = 0; viol = 0;
    strobes.delete();
    p_dr = 1'b0; p_df = 1'b1; p_fd = 1'b0; p_fin = 1'b1;
    end_result = '0;
    for (int t = 0; t < 5000 && o_busy; t++) begin
      if (o_dr && o_df) viol++;
      if (t > 0 && o_fd !== p_fd && (o_dr || o_df)) viol++;
      if (s_idx < 0 && o_fd) s_idx = t;
      if (v_idx < 0 && o_valid) begin v_idx = t; end_result = o_result; end
      if (err_idx < 0 && o_error) err_idx = t;
      if (o_dr) begin dr_high++; if (dr_first < 0) dr_first = t; end
      if (s_idx >= 0 && o_dr && !p_dr) strobes.push_back(2 + int'(o_fd));
      if (s_idx >= 0 && o_df && !p_df) strobes.push_back(int'(o_fd));
      if (!o_finish && p_fin) fin_falls++;
      p_dr = o_dr; p_df = o_df; p_fd = o_fd; p_fin = o_finish;
      if (probe && t == 20) begin num_a = 8'd1; start_a = 1'b1; end
      if (probe && t == 21) begin num_a = num[7:0]; start_a = 1'b0; end
      cyc();
    end
    end_valid = o_valid;
    end_error = o_error;
    chk("busy_low_end", o_busy, 0);
    chk("reset_high_end", o_reset, 1);
    chk("strobe_invariants", viol, 0);
    chk("settle_to_strobe", dr_first - s_idx, settle + 1);
    if (!freeze) begin
      chk("strobe_count", strobes.size(), 2 * n_eff);
      for (int i = 0; i < strobes.size() && i < 2 * n_eff; i++)
        chk("strobe_kind_fd", strobes[i], (i % 2 == 0) ? 3 : 0);
      chk("finish_low_once", fin_falls, 1);
      chk("result_valid", end_valid, 1);
      chk("error_clear", end_error, 0);
      exp_res = v_idx - s_idx;
      if (exp_res > res_max) exp_res = res_max;
      chk("result", end_result, exp_res);
    end else begin
      chk("timeout_dr_cycles", dr_high, TO);
      chk("timeout_error_at", err_idx - dr_first, TO);
      chk("timeout_error", end_error, 1);
      chk("timeout_valid", end_valid, 0);
      chk("timeout_no_finish", fin_falls, 0);
    end
    freeze_a = 1'b0;
    repeat (12) cyc();
  endtask

  initial begin
    bit seen, found;
    repeat (3) cyc();
    chk("rst_reset", a_reset, 1);
    chk("rst_finish", a_finish, 1);
    chk("rst_fd", a_fd, 0);
    chk("rst_dr", a_dr, 0);
    chk("rst_df", a_df, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_result", a_result, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_error", a_error, 0);
    chk("rst_sat_busy", b_busy, 0);
    #2 resetb = 1'b1;
    repeat (3) cyc();

    run_conv(1'b0, 3, 2, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++)
      run_conv(1'b0, int'($urandom_range(1, 4)), int'($urandom_range(0, 7)), 1'b0, 1'b0);
    run_conv(1'b0, 0, int'($urandom_range(0, 5)), 1'b0, 1'b0);
    run_conv(1'b0, 2, int'($urandom_range(0, 5)), 1'b1, 1'b0);

    sel_b = 1'b0;
    num_a = 8'd3; settle_a = 6'd4; start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    seen = 1'b0; found = 1'b0;
    for (int t = 0; t < 400 && !found; t++) begin
      if (a_dr) seen = 1'b1;
      else if (seen) found = 1'b1;
      if (!found) cyc();
    end
    chk("second_settle_reached", found, 1);
    chk("second_settle_fd", a_fd, 0);
    #2 resetb = 1'b0;
    #1;
    chk("amid_reset", a_reset, 1);
    chk("amid_finish", a_finish, 1);
    chk("amid_dr", a_dr, 0);
    chk("amid_df", a_df, 0);
    chk("amid_busy", a_busy, 0);
    chk("amid_result", a_result, 0);
    chk("amid_valid", a_valid, 0);
    chk("amid_fd", a_fd, 0);
    #10 resetb = 1'b1;
    repeat (12) cyc();

    run_conv(1'b1, 1, 63, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
